// File: rtl/clk_rst_manager.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_manager
// Description : Reset sequencer and fractional clock-enable generator that
//               sits behind the iCE40 PLL wrapper in the PLL output domain.
//               - Holds rst_out high until the double-flopped PLL lock has
//                 stayed high for LOCK_WAIT consecutive cycles.
//               - Produces NUM_CH DDS-style one-cycle enable strobes.
//                 Each strobe's rate is f_clk * inc / 2^ACC_W, and inc is
//                 programmable at runtime.
//               - Drops back into reset and sets the sticky lock_lost flag
//                 if lock is lost while running.
//
// Optional feature macro: CLKGEN_PHASE_RESET_EN
//               When defined, a cfg_wr to channel n also clears acc[n] on
//               the same edge, giving a deterministic phase after every
//               rate change. When undefined, rate changes are
//               phase-continuous.
//
// Ports:
//   clock_in   in   1       PLL output clock (only clock)
//   reset      in   1       synchronous, active-high
//   pll_locked in   1       PLL lock, asynchronous to clock_in
//   cfg_wr     in   1       increment register write strobe
//   cfg_sel    in   SEL_W   channel select (out-of-range writes ignored)
//   cfg_inc    in   ACC_W   new increment value
//   rst_out    out  1       system reset, active-high
//   sys_ready  out  1       high only in RUN
//   ce         out  NUM_CH  one-cycle clock-enable strobes
//   lock_lost  out  1       sticky: lock dropped while in RUN
//
// Revision    : 1.0 - initial release
// ============================================================================
module clk_rst_manager #(
    parameter int               NUM_CH    = 2,
    parameter int               ACC_W     = 16,
    parameter int               LOCK_WAIT = 1024,
    parameter logic [ACC_W-1:0] INC_INIT  = 16'h6B6B
) (
    input  logic                                      clock_in,
    input  logic                                      reset,
    input  logic                                      pll_locked,
    input  logic                                      cfg_wr,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_sel,
    input  logic [ACC_W-1:0]                          cfg_inc,
    output logic                                      rst_out,
    output logic                                      sys_ready,
    output logic [NUM_CH-1:0]                         ce,
    output logic                                      lock_lost
);

    localparam int c_SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_CNT_W = $clog2(LOCK_WAIT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    state_t               state_q;
    logic                 sync1_q;
    logic                 lock_s_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic                 rst_out_q;
    logic                 sys_ready_q;
    logic                 lock_lost_q;

    // ------------------------------------------------------------------------
    // Lock synchroniser and reset-release FSM. The outputs are registered
    // on the transition edge, so they change in the first cycle of the
    // new state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= '0;
            rst_out_q   <= 1'b1;
            sys_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
            case (state_q)
                S_WAIT_LOCK: begin
                    cnt_q <= '0;
                    if (lock_s_q) begin
                        state_q <= S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (!lock_s_q) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        rst_out_q   <= 1'b0;
                        sys_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s_q) begin
                        state_q     <= S_WAIT_LOCK;
                        rst_out_q   <= 1'b1;
                        sys_ready_q <= 1'b0;
                        lock_lost_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_WAIT_LOCK;
                    cnt_q       <= '0;
                    rst_out_q   <= 1'b1;
                    sys_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out   = rst_out_q;
    assign sys_ready = sys_ready_q;
    assign lock_lost = lock_lost_q;

    // Accumulate only while staying in RUN. On the edge that leaves RUN,
    // the accumulators clear and ce is not raised, so no strobe
    // appears once rst_out has reasserted.
    logic w_run_en;
    assign w_run_en = (state_q == S_RUN) && lock_s_q;

    // ------------------------------------------------------------------------
    // Per-channel phase accumulators
    // ------------------------------------------------------------------------
    generate
        for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
            logic [ACC_W-1:0] acc_q;
            logic [ACC_W-1:0] acc_d;
            logic [ACC_W-1:0] inc_q;
            logic [ACC_W-1:0] inc_d;
            logic             ce_q;
            logic             ce_d;
            logic             w_wr;
            logic [ACC_W:0]   w_sum;

            // A select value that has no matching channel matches no
            // generate instance, so that write is dropped.
            assign w_wr  = cfg_wr && (cfg_sel == c_SEL_W'(n));
            assign w_sum = {1'b0, acc_q} + {1'b0, inc_q};

            always_comb begin
                // The write lands in inc_q at this edge. This cycle's
                // addition still uses the old increment.
                inc_d = w_wr ? cfg_inc : inc_q;
                acc_d = '0;
                ce_d  = 1'b0;
                if (w_run_en) begin
                    acc_d = w_sum[ACC_W-1:0];
                    ce_d  = w_sum[ACC_W];
`ifdef CLKGEN_PHASE_RESET_EN
                    if (w_wr) begin
                        acc_d = '0;
                    end
`endif
                end
            end

            always_ff @(posedge clock_in) begin
                if (reset) begin
                    acc_q <= '0;
                    inc_q <= INC_INIT;
                    ce_q  <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    inc_q <= inc_d;
                    ce_q  <= ce_d;
                end
            end

            assign ce[n] = ce_q;
        end
    endgenerate

endmodule
`default_nettype wire
